// File: rtl/fetch_sequencer_if.sv
// Fetch-side bundle between the fetch sequencer, the instruction memory and decode.
// The master modport is the sequencer; the slave modport is its environment.
interface fetch_sequencer_if;
    logic        start;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halted;
    logic        fault;
    logic [15:0] fetch_count;

    modport master (
        input  start, mem_data, instr_ready, redirect_valid, redirect_pc,
        output mem_addr, instr, instr_pc, instr_valid, halted, fault, fetch_count
    );

    modport slave (
        output start, mem_data, instr_ready, redirect_valid, redirect_pc,
        input  mem_addr, instr, instr_pc, instr_valid, halted, fault, fetch_count
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, reads a combinational word memory
// and registers each fetched word into a single valid/ready slot toward decode.
// Halt word and illegal fetch addresses park the sequencer until reset.
module fetch_sequencer #(
    parameter int unsigned DEPTH     = 16,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic               clk,
    input  logic               rst,
    fetch_sequencer_if.master  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_HALT  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    localparam logic [31:0] LAST_PC = DEPTH * 32'd4 - 32'd4;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            sat_inc = v;
        end else begin
            sat_inc = v + 16'd1;
        end
    endfunction

    // A fetch address is legal only when word aligned and inside the memory.
    function automatic logic pc_illegal(input logic [31:0] pc);
        pc_illegal = (pc[1:0] != 2'b00) || (pc > LAST_PC);
    endfunction

    state_t      state_q,       state_d;
    logic [31:0] pc_q,          pc_d;
    logic [31:0] instr_q,       instr_d;
    logic [31:0] instr_pc_q,    instr_pc_d;
    logic        instr_valid_q, instr_valid_d;
    logic        halted_q,      halted_d;
    logic        fault_q,       fault_d;
    logic [15:0] fetch_count_q, fetch_count_d;
    logic        slot_free_s;

    // The output slot can take a new word when empty or being drained this cycle.
    assign slot_free_s = !instr_valid_q || bus.instr_ready;

    assign bus.mem_addr    = pc_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.halted      = halted_q;
    assign bus.fault       = fault_q;
    assign bus.fetch_count = fetch_count_q;

    // State register and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= 32'h0000_0000;
            instr_pc_q    <= 32'h0000_0000;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            fault_q       <= 1'b0;
            fetch_count_q <= 16'h0000;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            halted_q      <= halted_d;
            fault_q       <= fault_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    // Next state: redirect beats fetch; fetch only into a free slot; else hold.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        halted_d      = halted_q;
        fault_d       = fault_q;
        fetch_count_d = fetch_count_q;

        case (state_q)
            S_IDLE: begin
                // Start wins over a simultaneous redirect, which is simply ignored.
                if (bus.start) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (bus.redirect_valid) begin
                    // Held word is discarded even if decode is accepting it.
                    pc_d          = bus.redirect_pc;
                    instr_valid_d = 1'b0;
                end else if (slot_free_s) begin
                    if (pc_illegal(pc_q)) begin
                        state_d       = S_FAULT;
                        fault_d       = 1'b1;
                        instr_valid_d = 1'b0;
                    end else if (bus.mem_data == HALT_WORD) begin
                        // PC stays on the halt word.
                        state_d       = S_HALT;
                        halted_d      = 1'b1;
                        instr_valid_d = 1'b0;
                    end else begin
                        instr_d       = bus.mem_data;
                        instr_pc_d    = pc_q;
                        instr_valid_d = 1'b1;
                        pc_d          = pc_q + 32'd4;
                        fetch_count_d = sat_inc(fetch_count_q);
                    end
                end else begin
                    // Decode stalled on a held word: everything stays put.
                    instr_valid_d = instr_valid_q;
                end
            end
            S_HALT, S_FAULT: begin
                instr_valid_d = 1'b0;
            end
            default: begin
                state_d       = S_IDLE;
                instr_valid_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: stimulus pushes the program-order
// stream of words decode should receive; a negedge monitor pops and compares.
module tb_fetch_sequencer;

    localparam int          DEPTH = 16;
    localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

    typedef struct {
        logic [31:0] word;
        logic [31:0] pc;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [31:0] mem [DEPTH];
    beat_t sb_q [$];
    int tests  = 0;
    int failed = 0;

    fetch_sequencer_if ifc ();

    fetch_sequencer #(
        .DEPTH     (DEPTH),
        .RESET_PC  (32'h0000_0000),
        .HALT_WORD (HALT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    // Instruction memory: combinational read, out-of-range reads return zero.
    always_comb begin
        if (ifc.mem_addr[31:2] < DEPTH) ifc.mem_data = mem[ifc.mem_addr[5:2]];
        else                            ifc.mem_data = 32'h0000_0000;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: a beat is delivered when valid & ready and no redirect discards it.
    always @(negedge clk) begin
        if (!rst && ifc.instr_valid && ifc.instr_ready && !ifc.redirect_valid) begin
            if (sb_q.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL unexpected_beat: got %h at pc %h, expected none", ifc.instr, ifc.instr_pc);
            end else begin
                beat_t e;
                e = sb_q.pop_front();
                chk("beat_word", ifc.instr, e.word);
                chk("beat_pc", ifc.instr_pc, e.pc);
            end
        end
    end

    task automatic do_reset();
        sb_q.delete();
        rst = 1'b1;
        ifc.start = 1'b0;
        ifc.redirect_valid = 1'b0;
        ifc.redirect_pc = 32'h0000_0000;
        ifc.instr_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic load_straight();
        mem[0] = 32'h003100B3; mem[1] = 32'h00308233; mem[2] = 32'h401202B3;
        mem[3] = 32'h00528313; mem[4] = 32'h00331393; mem[5] = 32'h0002A403;
        mem[6] = 32'h0072A223; mem[7] = HALT;
        for (int i = 8; i < DEPTH; i++) mem[i] = 32'h0000_0013;
    endtask

    // Expected stream: consecutive words in program order from a start index.
    task automatic push_range(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            beat_t b;
            b.word = mem[first + i];
            b.pc   = 32'((first + i) * 4);
            sb_q.push_back(b);
        end
    endtask

    task automatic pulse_start();
        ifc.start = 1'b1;
        @(posedge clk); #1;
        ifc.start = 1'b0;
    endtask

    // Clock until halted or fault, with optional random backpressure.
    task automatic run_to_end(input int bound, input bit rand_ready, output int cycles);
        cycles = 0;
        while (!(ifc.halted || ifc.fault) && cycles < bound) begin
            ifc.instr_ready = rand_ready ? ($urandom_range(0, 99) < 60) : 1'b1;
            @(posedge clk); #1;
            cycles++;
        end
        if (!(ifc.halted || ifc.fault)) begin
            tests++;
            failed++;
            $display("FAIL run_timeout: got no halt/fault, expected one within %0d cycles", bound);
        end
        ifc.instr_ready = 1'b1;
    endtask

    initial begin
        int cyc;
        ifc.start = 1'b0;
        ifc.redirect_valid = 1'b0;
        ifc.redirect_pc = 32'h0000_0000;
        ifc.instr_ready = 1'b0;
        load_straight();

        // Reset state
        do_reset();
        chk("rst_valid", 32'(ifc.instr_valid), 32'd0);
        chk("rst_instr", ifc.instr, 32'd0);
        chk("rst_instr_pc", ifc.instr_pc, 32'd0);
        chk("rst_addr", ifc.mem_addr, 32'd0);
        chk("rst_flags", {30'd0, ifc.halted, ifc.fault}, 32'd0);
        chk("rst_count", 32'(ifc.fetch_count), 32'd0);

        // Straight run: seven beats, halt eight edges after start
        push_range(0, 7);
        pulse_start();
        run_to_end(50, 1'b0, cyc);
        chk("straight_latency", 32'(cyc), 32'd8);
        chk("straight_halted", 32'(ifc.halted), 32'd1);
        chk("straight_count", 32'(ifc.fetch_count), 32'd7);
        chk("straight_addr", ifc.mem_addr, 32'd28);
        @(posedge clk); #1;
        chk("straight_valid_after", 32'(ifc.instr_valid), 32'd0);
        chk("straight_sb_empty", 32'(sb_q.size()), 32'd0);

        // Backpressure: word 0 held stable for three stalled cycles
        do_reset();
        push_range(0, 7);
        pulse_start();
        @(posedge clk); #1;
        chk("bp_valid", 32'(ifc.instr_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp_instr", ifc.instr, 32'h003100B3);
            chk("bp_instr_pc", ifc.instr_pc, 32'd0);
            chk("bp_pc", ifc.mem_addr, 32'd4);
            chk("bp_count", 32'(ifc.fetch_count), 32'd1);
        end
        run_to_end(50, 1'b0, cyc);
        chk("bp_halted", 32'(ifc.halted), 32'd1);
        chk("bp_sb_empty", 32'(sb_q.size()), 32'd0);

        // Redirect flush while word 2 is presented
        do_reset();
        push_range(0, 2);
        push_range(5, 2);
        ifc.instr_ready = 1'b1;
        pulse_start();
        cyc = 0;
        while (!(ifc.instr_valid && ifc.instr_pc == 32'd8) && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("redir_reach_word2", ifc.instr, 32'h401202B3);
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc = 32'h0000_0014;
        @(posedge clk); #1;
        ifc.redirect_valid = 1'b0;
        chk("redir_flush_valid", 32'(ifc.instr_valid), 32'd0);
        chk("redir_pc", ifc.mem_addr, 32'h14);
        run_to_end(50, 1'b0, cyc);
        chk("redir_count", 32'(ifc.fetch_count), 32'd5);
        chk("redir_sb_empty", 32'(sb_q.size()), 32'd0);

        // Start and redirect together in IDLE: redirect ignored
        do_reset();
        push_range(0, 7);
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc = 32'h0000_0014;
        pulse_start();
        ifc.redirect_valid = 1'b0;
        run_to_end(50, 1'b0, cyc);
        chk("idle_redir_count", 32'(ifc.fetch_count), 32'd7);
        chk("idle_redir_sb_empty", 32'(sb_q.size()), 32'd0);

        // Out-of-range redirect faults on the next fetch attempt
        do_reset();
        ifc.instr_ready = 1'b1;
        pulse_start();
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc = 32'h0000_0040;
        @(posedge clk); #1;
        ifc.redirect_valid = 1'b0;
        chk("oor_no_fault_yet", 32'(ifc.fault), 32'd0);
        run_to_end(10, 1'b0, cyc);
        chk("oor_fault", 32'(ifc.fault), 32'd1);
        chk("oor_count", 32'(ifc.fetch_count), 32'd0);
        chk("oor_halted", 32'(ifc.halted), 32'd0);

        // Misaligned redirect faults; start and redirect then ignored
        do_reset();
        ifc.instr_ready = 1'b1;
        pulse_start();
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc = 32'h0000_0006;
        @(posedge clk); #1;
        ifc.redirect_valid = 1'b0;
        run_to_end(10, 1'b0, cyc);
        chk("mis_fault", 32'(ifc.fault), 32'd1);
        pulse_start();
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc = 32'h0000_0000;
        @(posedge clk); #1;
        ifc.redirect_valid = 1'b0;
        @(posedge clk); #1;
        chk("mis_sticky_fault", 32'(ifc.fault), 32'd1);
        chk("mis_pc_frozen", ifc.mem_addr, 32'd6);
        chk("mis_valid", 32'(ifc.instr_valid), 32'd0);
        chk("mis_count", 32'(ifc.fetch_count), 32'd0);

        // Reset during a backpressure stall
        do_reset();
        push_range(0, 7);
        pulse_start();
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("stall_valid", 32'(ifc.instr_valid), 32'd1);
        do_reset();
        chk("mrst_valid", 32'(ifc.instr_valid), 32'd0);
        chk("mrst_instr", ifc.instr, 32'd0);
        chk("mrst_addr", ifc.mem_addr, 32'd0);
        chk("mrst_count", 32'(ifc.fetch_count), 32'd0);
        ifc.instr_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mrst_idle_no_fetch", {ifc.instr_valid, 15'd0, ifc.fetch_count}, 32'd0);
        push_range(0, 7);
        pulse_start();
        run_to_end(50, 1'b0, cyc);
        chk("mrst_count_end", 32'(ifc.fetch_count), 32'd7);
        chk("mrst_sb_empty", 32'(sb_q.size()), 32'd0);

        // Saturation of the delivered-instruction counter
        do_reset();
        force dut.fetch_count_q = 16'hFFFE;
        @(posedge clk); #1;
        release dut.fetch_count_q;
        chk("sat_preload", 32'(ifc.fetch_count), 32'h0000_FFFE);
        push_range(0, 7);
        ifc.instr_ready = 1'b1;
        pulse_start();
        @(posedge clk); #1;
        chk("sat_first", 32'(ifc.fetch_count), 32'h0000_FFFF);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("sat_third", 32'(ifc.fetch_count), 32'h0000_FFFF);
        run_to_end(50, 1'b0, cyc);
        chk("sat_end", 32'(ifc.fetch_count), 32'h0000_FFFF);
        chk("sat_sb_empty", 32'(sb_q.size()), 32'd0);

        // Random programs with random backpressure: halt at k, or run off the end
        for (int it = 0; it < 20; it++) begin
            int k;
            k = $urandom_range(0, DEPTH);
            for (int i = 0; i < DEPTH; i++) begin
                logic [31:0] w;
                w = $urandom();
                if (w == HALT) w = 32'h0000_0013;
                mem[i] = (i == k) ? HALT : w;
            end
            do_reset();
            push_range(0, k);
            pulse_start();
            run_to_end(400, 1'b1, cyc);
            chk("rnd_halted", 32'(ifc.halted), (k < DEPTH) ? 32'd1 : 32'd0);
            chk("rnd_fault", 32'(ifc.fault), (k == DEPTH) ? 32'd1 : 32'd0);
            chk("rnd_count", 32'(ifc.fetch_count), 32'(k));
            chk("rnd_pc", ifc.mem_addr, 32'(k * 4));
            @(posedge clk); #1;
            chk("rnd_valid", 32'(ifc.instr_valid), 32'd0);
            chk("rnd_sb_empty", 32'(sb_q.size()), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    // Watchdog against a stuck run.
    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction-fetch controller that sequences the word-addressed instruction memory (combinational read, byte address, word index = address >> 2). It owns the program counter, drives the memory address, and registers each fetched word into a valid/ready output stage toward decode. It detects the halt word, accepts PC redirects, and flags out-of-range or misaligned fetches.

Parameters:
DEPTH, 16, number of 32-bit words in instruction memory; legal byte PCs are 0 to DEPTH*4-4.
RESET_PC, 32'h0, PC value loaded on reset.
HALT_WORD, 32'hFFFFFFFF, instruction encoding that stops fetch.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  leave IDLE and begin fetching; ignored outside IDLE.
mem_addr  output  32  byte address to instruction memory; always equals the pc register.
mem_data  input  32  combinational read data for mem_addr.
instr  output  32  registered instruction word.
instr_pc  output  32  byte PC of instr.
instr_valid  output  1  instr/instr_pc hold a valid instruction.
instr_ready  input  1  decode accepts instr this cycle when instr_valid=1.
redirect_valid  input  1  load redirect_pc and flush the output stage.
redirect_pc  input  32  new byte PC.
halted  output  1  HALT_WORD fetched; sticky until rst.
fault  output  1  illegal fetch address; sticky until rst.
fetch_count  output  16  instructions delivered into the output stage; saturates at 16'hFFFF.

Behaviour:
- Reset (rst=1 at edge): state=IDLE, pc=RESET_PC, instr=0, instr_pc=0, instr_valid=0, halted=0, fault=0, fetch_count=0. rst has priority over all inputs and applies in any state, including mid-stall.
- States: IDLE, RUN, HALT, FAULT.
- IDLE: start=1 -> RUN next cycle. No fetch occurs in IDLE.
- RUN, priority order per cycle:
  1. redirect_valid=1: pc<=redirect_pc; instr_valid<=0, which discards any held instruction even when instr_ready=1; no fetch this cycle.
  2. Slot free (instr_valid=0, or instr_valid=1 and instr_ready=1): fetch at pc:
     - pc[1:0]!=0 or pc>DEPTH*4-4 -> FAULT; fault<=1; instr_valid<=0.
     - mem_data==HALT_WORD -> HALT; halted<=1; instr_valid<=0; pc unchanged.
     - otherwise instr<=mem_data, instr_pc<=pc, instr_valid<=1, pc<=pc+4 (32-bit wrap), fetch_count<=fetch_count+1 (saturating).
  3. Slot occupied and instr_ready=0: hold instr, instr_pc, instr_valid, pc, and fetch_count stable.
- Latency: start sampled at edge N, state is RUN after N, and instr_valid=1 with word 0 after edge N+1. With instr_ready held at 1, throughput is one instruction per cycle.
- HALT and FAULT: terminal until rst. start and redirect_valid are ignored. instr_valid stays 0. A held instruction is dropped on the transition only if it was being consumed that cycle; fetch cannot occur otherwise, so no instruction is lost.
- Redirect to an illegal PC is not checked at load; fault is raised on the next fetch attempt.
- mem_addr is driven combinationally from the pc register, with no added latency.
- Simultaneous start and redirect_valid in IDLE: start is taken and redirect is ignored.

Test Plan:
- Straight run: memory words 0..7 = 003100B3, 00308233, 401202B3, 00528313, 00331393, 0002A403, 0072A223, FFFFFFFF; rst, then start, instr_ready=1 -> seven beats with instr_pc 0,4,...,24; halted=1 on the cycle after the last beat; fetch_count=7; instr_valid=0 thereafter.
- Backpressure: instr_ready=0 for 3 cycles while instr=003100B3 is valid -> instr, instr_pc=0, pc=4, and fetch_count=1 all stable; on release, next beat is 00308233 at pc 4.
- Redirect flush: redirect_valid=1 with redirect_pc=0x14 while instr 401202B3 is valid -> instr_valid=0 the next cycle, then 0002A403 delivered with instr_pc=0x14.
- Faults: redirect_pc=0x40 -> fault=1 with no beat delivered; after rst, redirect_pc=0x6 -> fault=1; start is then ignored until rst.
- Reset mid-operation: assert rst during a backpressure stall -> all outputs return to reset values the next cycle and state is IDLE; the fetch sequence restarts at 0 after start.
- Saturation: force fetch_count to 16'hFFFE, then deliver 3 beats -> fetch_count reads 16'hFFFF and does not wrap.
